// File: rtl/sram_2p_march_bist.sv
// March C- BIST initiator for a 2-port SRAM macro with BIST muxing.
// Drives the port-A BIST inputs, compares A_DOUT against the expected
// background and keeps port B's BIST mux engaged (and idle) while testing.
module sram_2p_march_bist #(
    parameter int                      P_DATA_WIDTH = 20,
    parameter int                      P_ADDR_WIDTH = 9,
    parameter logic [P_DATA_WIDTH-1:0] P_BACKGROUND = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic                    B_BIST_EN,
    output logic                    B_BIST_MEN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [7:0]              FAIL_COUNT
);

    localparam int                  N_WORDS   = 2 ** P_ADDR_WIDTH;
    // One spare bit so the counter can never alias the end condition.
    localparam int                  CW        = P_ADDR_WIDTH + 1;
    localparam logic [CW-1:0]       ADDR_LAST = CW'(N_WORDS - 1);
    localparam logic [CW-1:0]       ADDR_ONE  = CW'(1);
    localparam logic [2:0]          ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Elements 3 and 4 sweep downwards, all others upwards.
    function automatic logic elem_is_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // Elements 1..4 are (read, write) pairs; 0 is write-only, 5 is read-only.
    function automatic logic elem_is_two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    // Value a read in element e must return ("1" reads in E2 and E4).
    function automatic logic [P_DATA_WIDTH-1:0] elem_read_data(input logic [2:0] e);
        return ((e == 3'd2) || (e == 3'd4)) ? ~P_BACKGROUND : P_BACKGROUND;
    endfunction

    // Value a write in element e stores ("1" writes in E1 and E3).
    function automatic logic [P_DATA_WIDTH-1:0] elem_write_data(input logic [2:0] e);
        return ((e == 3'd1) || (e == 3'd3)) ? ~P_BACKGROUND : P_BACKGROUND;
    endfunction

    // First address of element e.
    function automatic logic [CW-1:0] elem_start_addr(input logic [2:0] e);
        return elem_is_down(e) ? ADDR_LAST : '0;
    endfunction

    // Sequencer state: describes the operation currently on the outputs.
    state_t                  state_r,  state_s;
    logic [2:0]              elem_r,   elem_s;
    logic [CW-1:0]           addr_r,   addr_s;
    logic                    wr_r,     wr_s;
    logic                    clr_s;
    logic                    at_last_s;

    // Registered output copies.
    logic                    a_en_r;
    logic [P_ADDR_WIDTH-1:0] a_addr_r;
    logic [P_DATA_WIDTH-1:0] a_din_r;
    logic [P_DATA_WIDTH-1:0] a_bm_r;
    logic                    a_men_r;
    logic                    a_wen_r;
    logic                    a_ren_r;
    logic                    busy_r;
    logic                    done_r;
    logic [P_DATA_WIDTH-1:0] cur_exp_r;

    // Compare pipeline and results.
    logic                    cmp_valid_r;
    logic [P_DATA_WIDTH-1:0] cmp_exp_r;
    logic [P_ADDR_WIDTH-1:0] cmp_addr_r;
    logic                    miscmp_s;
    logic                    fail_r;
    logic [P_ADDR_WIDTH-1:0] fail_addr_r;
    logic [7:0]              fail_count_r;

    logic                    run_s;
    logic                    act_s;

    // Element end detection for the operation currently issued.
    always_comb begin
        at_last_s = 1'b0;
        if (elem_is_down(elem_r)) begin
            at_last_s = (addr_r == '0);
        end else begin
            at_last_s = (addr_r == ADDR_LAST);
        end
    end

    // Next-state / next-operation selection for the March sequencer.
    always_comb begin
        state_s = state_r;
        elem_s  = elem_r;
        addr_s  = addr_r;
        wr_s    = wr_r;
        clr_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_s = ST_RUN;
                    elem_s  = 3'd0;
                    addr_s  = '0;
                    wr_s    = 1'b1;
                    clr_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (elem_is_two_op(elem_r) && !wr_r) begin
                    // Read half done: write at the same address.
                    wr_s = 1'b1;
                end else if (at_last_s) begin
                    if (elem_r == ELEM_LAST) begin
                        state_s = ST_DRAIN;
                    end else begin
                        elem_s = elem_r + 3'd1;
                        addr_s = elem_start_addr(elem_r + 3'd1);
                        wr_s   = 1'b0;
                    end
                end else begin
                    if (elem_is_down(elem_r)) begin
                        addr_s = addr_r - ADDR_ONE;
                    end else begin
                        addr_s = addr_r + ADDR_ONE;
                    end
                    // Only element 0 starts each address with a write.
                    wr_s = (elem_r == 3'd0);
                end
            end
            ST_DRAIN: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign run_s = (state_s == ST_RUN);
    assign act_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);

    // Sequencer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            elem_r  <= 3'd0;
            addr_r  <= '0;
            wr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            elem_r  <= elem_s;
            addr_r  <= addr_s;
            wr_r    <= wr_s;
        end
    end

    // Output registers, loaded with the operation chosen for the next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_en_r    <= 1'b0;
            a_addr_r  <= '0;
            a_din_r   <= '0;
            a_bm_r    <= '0;
            a_men_r   <= 1'b0;
            a_wen_r   <= 1'b0;
            a_ren_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cur_exp_r <= '0;
        end else begin
            a_en_r    <= act_s;
            a_addr_r  <= run_s ? addr_s[P_ADDR_WIDTH-1:0] : '0;
            a_din_r   <= (run_s && wr_s) ? elem_write_data(elem_s) : '0;
            a_bm_r    <= act_s ? '1 : '0;
            a_men_r   <= run_s;
            a_wen_r   <= run_s && wr_s;
            a_ren_r   <= run_s && !wr_s;
            busy_r    <= act_s;
            done_r    <= (state_s == ST_DONE);
            cur_exp_r <= elem_read_data(elem_s);
        end
    end

    // Capture expected data and address at the edge that launches a read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmp_valid_r <= 1'b0;
            cmp_exp_r   <= '0;
            cmp_addr_r  <= '0;
        end else begin
            cmp_valid_r <= a_ren_r;
            cmp_exp_r   <= cur_exp_r;
            cmp_addr_r  <= a_addr_r;
        end
    end

    // Miscompare decision; an unknown read word falls to the mismatch branch.
    always_comb begin
        miscmp_s = 1'b0;
        if (cmp_valid_r) begin
            if (A_DOUT == cmp_exp_r) begin
                miscmp_s = 1'b0;
            end else begin
                miscmp_s = 1'b1;
            end
        end else begin
            miscmp_s = 1'b0;
        end
    end

    // Sticky result registers, cleared when a new test is launched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fail_r       <= 1'b0;
            fail_addr_r  <= '0;
            fail_count_r <= 8'd0;
        end else if (clr_s) begin
            fail_r       <= 1'b0;
            fail_addr_r  <= '0;
            fail_count_r <= 8'd0;
        end else if (miscmp_s) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
                fail_addr_r <= cmp_addr_r;
            end else begin
                fail_addr_r <= fail_addr_r;
            end
            if (fail_count_r != 8'hFF) begin
                fail_count_r <= fail_count_r + 8'd1;
            end else begin
                fail_count_r <= fail_count_r;
            end
        end else begin
            fail_r       <= fail_r;
            fail_addr_r  <= fail_addr_r;
            fail_count_r <= fail_count_r;
        end
    end

    assign A_BIST_EN   = a_en_r;
    assign A_BIST_ADDR = a_addr_r;
    assign A_BIST_DIN  = a_din_r;
    assign A_BIST_BM   = a_bm_r;
    assign A_BIST_MEN  = a_men_r;
    assign A_BIST_WEN  = a_wen_r;
    assign A_BIST_REN  = a_ren_r;
    assign B_BIST_EN   = busy_r;
    assign B_BIST_MEN  = 1'b0;
    assign BUSY        = busy_r;
    assign DONE        = done_r;
    assign FAIL        = fail_r;
    assign FAIL_ADDR   = fail_addr_r;
    assign FAIL_COUNT  = fail_count_r;

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Directed bench for sram_2p_march_bist with a small 2-port SRAM model
// (BIST muxing on both ports, read-side stuck-at fault masks).
module tb_sram_2p_march_bist;

    localparam int DW = 20;
    localparam int AW = 4;
    localparam int NW = 16;
    localparam int LAST_CYC = 10 * NW + 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [DW-1:0] a_dout;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic          B_BIST_EN, B_BIST_MEN, BUSY, DONE, FAIL;
    logic [AW-1:0] FAIL_ADDR;
    logic [7:0]    FAIL_COUNT;

    // Functional port-B traffic and effective (muxed) port-B controls.
    logic          fn_b_men = 1'b0;
    logic          fn_b_wen = 1'b0;
    logic [AW-1:0] fn_b_addr = 4'd7;
    logic [DW-1:0] fn_b_din = 20'h12345;
    logic          b_men_s, b_wen_s;

    logic [DW-1:0] mem_arr  [0:NW-1];
    logic [DW-1:0] sa1_mask [0:NW-1];
    logic [DW-1:0] sa0_mask [0:NW-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    sram_2p_march_bist #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW),
        .P_BACKGROUND (20'h00000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .A_DOUT      (a_dout),
        .A_BIST_EN   (A_BIST_EN),
        .A_BIST_ADDR (A_BIST_ADDR),
        .A_BIST_DIN  (A_BIST_DIN),
        .A_BIST_BM   (A_BIST_BM),
        .A_BIST_MEN  (A_BIST_MEN),
        .A_BIST_WEN  (A_BIST_WEN),
        .A_BIST_REN  (A_BIST_REN),
        .B_BIST_EN   (B_BIST_EN),
        .B_BIST_MEN  (B_BIST_MEN),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .FAIL        (FAIL),
        .FAIL_ADDR   (FAIL_ADDR),
        .FAIL_COUNT  (FAIL_COUNT)
    );

    assign b_men_s = B_BIST_EN ? B_BIST_MEN : fn_b_men;
    assign b_wen_s = B_BIST_EN ? 1'b0 : fn_b_wen;

    // SRAM model: port A driven only by BIST here, port B functional unless muxed off.
    always @(posedge CLK) begin
        if (A_BIST_EN && A_BIST_MEN) begin
            if (A_BIST_WEN)
                mem_arr[A_BIST_ADDR] <= (A_BIST_DIN & A_BIST_BM) | (mem_arr[A_BIST_ADDR] & ~A_BIST_BM);
            if (A_BIST_REN)
                a_dout <= (mem_arr[A_BIST_ADDR] | sa1_mask[A_BIST_ADDR]) & ~sa0_mask[A_BIST_ADDR];
        end
        if (b_men_s && b_wen_s)
            mem_arr[fn_b_addr] <= fn_b_din;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NW; i++) begin
            sa1_mask[i] = '0;
            sa0_mask[i] = '0;
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // Full run from a START pulse to the first DONE cycle, with timing checks.
    task automatic run_march(input string tag, input logic exp_fail,
                             input int exp_addr, input int exp_cnt);
        int busy_cnt;
        int first_busy;
        int last_busy;
        busy_cnt   = 0;
        first_busy = -1;
        last_busy  = -1;
        pulse_start();
        for (int c = 1; c <= LAST_CYC; c++) begin
            @(negedge CLK);
            if (BUSY) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (c == 1) begin
                check_eq({tag, " c1 busy"},  BUSY, 1);
                check_eq({tag, " c1 a_en"},  A_BIST_EN, 1);
                check_eq({tag, " c1 b_en"},  B_BIST_EN, 1);
                check_eq({tag, " c1 b_men"}, B_BIST_MEN, 0);
                check_eq({tag, " c1 wen"},   {A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 3'b110);
                check_eq({tag, " c1 addr"},  A_BIST_ADDR, 0);
                check_eq({tag, " c1 din"},   A_BIST_DIN, 20'h00000);
                check_eq({tag, " c1 bm"},    A_BIST_BM, 20'hFFFFF);
                check_eq({tag, " c1 done"},  DONE, 0);
                check_eq({tag, " c1 fail"},  {FAIL, FAIL_COUNT}, 9'd0);
            end
            if (c == 2)  check_eq({tag, " e0 addr1"}, A_BIST_ADDR, 1);
            if (c == 17) check_eq({tag, " e1 r0"}, {A_BIST_WEN, A_BIST_REN, A_BIST_ADDR}, {2'b01, 4'd0});
            if (c == 18) begin
                check_eq({tag, " e1 w1"},   {A_BIST_WEN, A_BIST_REN, A_BIST_ADDR}, {2'b10, 4'd0});
                check_eq({tag, " e1 din"},  A_BIST_DIN, 20'hFFFFF);
            end
            if (c == 19) check_eq({tag, " e1 addr1"}, A_BIST_ADDR, 1);
            if (c == 81) check_eq({tag, " e3 start"}, {A_BIST_REN, A_BIST_ADDR}, {1'b1, 4'd15});
            if (c == 160) check_eq({tag, " e5 last"}, {A_BIST_REN, A_BIST_ADDR}, {1'b1, 4'd15});
            if (c == 161) begin
                check_eq({tag, " drain busy"}, BUSY, 1);
                check_eq({tag, " drain men"},  {A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 3'b000);
                check_eq({tag, " drain done"}, DONE, 0);
            end
        end
        check_eq({tag, " done"},       DONE, 1);
        check_eq({tag, " done busy"},  BUSY, 0);
        check_eq({tag, " done en"},    {A_BIST_EN, B_BIST_EN}, 2'b00);
        check_eq({tag, " done ops"},   {A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 3'b000);
        check_eq({tag, " busy cnt"},   busy_cnt, 161);
        check_eq({tag, " busy first"}, first_busy, 1);
        check_eq({tag, " busy last"},  last_busy, 161);
        check_eq({tag, " fail"},       FAIL, exp_fail);
        check_eq({tag, " fail addr"},  FAIL_ADDR, exp_addr);
        check_eq({tag, " fail cnt"},   FAIL_COUNT, exp_cnt);
    endtask

    initial begin
        clear_faults();
        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst busy", BUSY, 0);
        check_eq("rst en",   {A_BIST_EN, B_BIST_EN, B_BIST_MEN}, 3'b000);
        check_eq("rst ops",  {A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 3'b000);
        check_eq("rst bm",   A_BIST_BM, 0);
        check_eq("rst res",  {DONE, FAIL, FAIL_ADDR, FAIL_COUNT}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Ideal SRAM with functional port-B writes to address 7 held active.
        fn_b_men = 1'b1;
        fn_b_wen = 1'b1;
        run_march("ideal", 1'b0, 0, 0);
        @(negedge CLK);
        check_eq("portb after done", mem_arr[7], 20'h12345);
        fn_b_men = 1'b0;
        fn_b_wen = 1'b0;

        // Stuck-at-1 on address 5 bit 3: every "0" read there misses.
        sa1_mask[5] = 20'h00008;
        run_march("sa1", 1'b1, 5, 3);

        // Restart from DONE with the fault removed.
        clear_faults();
        run_march("restart", 1'b0, 0, 0);

        // Stuck-at-0 bits at addresses 2 and 9: every "1" read there misses.
        sa0_mask[2] = 20'h00001;
        sa0_mask[9] = 20'h00080;
        run_march("sa0", 1'b1, 2, 4);

        // Reset in the middle of E2 (E2 spans cycles 49..80).
        pulse_start();
        repeat (60) @(negedge CLK);
        check_eq("mid busy",   BUSY, 1);
        check_eq("mid fail",   {FAIL, FAIL_ADDR, FAIL_COUNT}, {1'b1, 4'd2, 8'd1});
        RST = 1'b1;
        @(negedge CLK);
        check_eq("mrst busy",  BUSY, 0);
        check_eq("mrst en",    {A_BIST_EN, B_BIST_EN}, 2'b00);
        check_eq("mrst ops",   {A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 3'b000);
        check_eq("mrst res",   {DONE, FAIL, FAIL_COUNT}, 0);
        RST = 1'b0;
        clear_faults();
        run_march("after rst", 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
